imem_rotbuf: RTL
================

Name: imem_rotbuf

Overview:
- Parametrised N-bank rotating instruction buffer for the PE.
- The Program Launcher streams programs into free banks while the PE fetches from the current read bank.
- A read-side switch retires the current bank and advances to the next committed bank.
- Adds per-bank program length, commit tracking, write backpressure and zero-fill (NOP) of out-of-range fetches.

Parameters:
INST_WIDTH, 64, instruction word width in bits
INST_WORD, 32, words per bank (power of 2, >=2)
NUM_BANKS, 3, number of rotating banks (>=2)
ID_WIDTH, 2, width of PE id field on the write bus
ID, 3, id this instance responds to
(AW = $clog2(INST_WORD); LW = $clog2(INST_WORD+1); CW = $clog2(NUM_BANKS+1))

Ports:
clk  in  1  clock
rst  in  1  asynchronous reset, active-high
wr_valid_i  in  1  write word valid from Program Launcher
wr_id_i  in  ID_WIDTH  target PE id
wr_last_i  in  1  current word is last of program; commits bank
wr_data_i  in  INST_WIDTH  instruction word
wr_ready_o  out  1  a free bank exists; write accepted this cycle if valid & id match
rd_en_i  in  1  fetch request
rd_addr_i  in  AW  fetch address within current read bank
rd_data_o  out  INST_WIDTH  fetched word
rd_valid_o  out  1  rd_data_o valid (1 cycle after accepted fetch)
rd_switch_i  in  1  retire current read bank
rd_switch_ack_o  out  1  switch accepted this cycle (combinational)
bank_ready_o  out  1  current read bank holds a committed program
rd_len_o  out  LW  word count of current read bank (0 if not ready)
full_count_o  out  CW  number of committed banks

Behaviour:
- State: rptr, wptr (0..NUM_BANKS-1, wrap at NUM_BANKS), waddr (AW), count (CW), len[NUM_BANKS] (LW each). Invariant: wptr == (rptr+count) mod NUM_BANKS.
- Reset (async, rst=1): rptr=wptr=waddr=count=0, all len=0; rd_data_o=0, rd_valid_o=0. Memory contents are not cleared. Partial writes in progress are discarded.
- wr_ready_o = (count < NUM_BANKS).
- Write accept: wr_valid_i & (wr_id_i==ID) & wr_ready_o. Accepted word is stored at bank[wptr][waddr], then waddr++.
  - Valid with id mismatch or with wr_ready_o=0: word dropped, no state change.
- Commit occurs on an accepted word with wr_last_i=1, or on an accepted word at waddr==INST_WORD-1 (forced commit, no wrap).
  - On commit: len[wptr]=waddr+1, wptr advances, waddr=0, count++.
- bank_ready_o = (count != 0).
- rd_switch_ack_o = rd_switch_i & (count != 0).
  - On ack: rptr advances, count--, len[old rptr]=0.
  - rd_switch_i with count==0 is ignored.
- Commit and switch in the same cycle: count unchanged, both pointers advance.
- Fetch accept: rd_en_i & bank_ready_o.
  - Next cycle: rd_valid_o=1; rd_data_o = bank[rptr][rd_addr_i] if rd_addr_i < len[rptr], else 0 (NOP). rptr is sampled before any same-cycle switch.
  - rd_en_i with bank_ready_o=0: rd_valid_o=0 next cycle, rd_data_o holds.
  - rd_data_o holds its last value whenever rd_valid_o=0.
- Same-cycle fetch and write never touch the same bank: wptr is never a committed bank while count < NUM_BANKS.
- rd_len_o = bank_ready_o ? len[rptr] : 0. full_count_o = count.
- Memory is a behavioural array: one write port, one synchronous read port per bank, mappable to single-port SRAM banks.

Test Plan:
- Reset, write 5 words (id=3, last on 5th, data 0x100..0x104) -> full_count_o=1, bank_ready_o=1, rd_len_o=5; fetch addr 2 -> rd_data_o=0x102 one cycle later with rd_valid_o=1.
- Fetch addr 7 in the same bank -> rd_data_o=0, rd_valid_o=1. Write with id=1 -> ignored, full_count_o unchanged.
- Commit 3 programs (NUM_BANKS=3) -> wr_ready_o=0; a 4th write is dropped. Assert rd_switch_i -> ack=1, full_count_o=2, wr_ready_o=1, next fetch returns program 2 data.
- Write 32 words with no last -> forced commit, rd_len_o=32 for that bank, waddr returns to 0. Next word starts a new bank.
- Same cycle: commit of program N and rd_switch_i with count=2 -> count stays 2, rptr and wptr each advance by 1; a fetch issued that cycle returns old-bank data.
- Assert rst mid-program after 3 words -> full_count_o=0, bank_ready_o=0, rd_valid_o=0, wr_ready_o=1. A fresh 2-word program then commits with rd_len_o=2.

Source files
------------

// File: rtl/imem_rotbuf.sv
// imem_rotbuf: N-bank rotating instruction buffer for the PE.
// Launcher fills free banks; the PE fetches from the oldest committed bank.
module imem_rotbuf #(
    parameter  int INST_WIDTH = 64,
    parameter  int INST_WORD  = 32,
    parameter  int NUM_BANKS  = 3,
    parameter  int ID_WIDTH   = 2,
    parameter  int ID         = 3,
    localparam int AW         = $clog2(INST_WORD),
    localparam int LW         = $clog2(INST_WORD + 1),
    localparam int CW         = $clog2(NUM_BANKS + 1)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  wr_valid_i,
    input  logic [ID_WIDTH-1:0]   wr_id_i,
    input  logic                  wr_last_i,
    input  logic [INST_WIDTH-1:0] wr_data_i,
    output logic                  wr_ready_o,
    input  logic                  rd_en_i,
    input  logic [AW-1:0]         rd_addr_i,
    output logic [INST_WIDTH-1:0] rd_data_o,
    output logic                  rd_valid_o,
    input  logic                  rd_switch_i,
    output logic                  rd_switch_ack_o,
    output logic                  bank_ready_o,
    output logic [LW-1:0]         rd_len_o,
    output logic [CW-1:0]         full_count_o
);

    localparam int PW = $clog2(NUM_BANKS);

    logic [INST_WIDTH-1:0] r_mem [NUM_BANKS][INST_WORD];
    logic [LW-1:0]         r_len [NUM_BANKS];
    logic [PW-1:0]         r_rptr;
    logic [PW-1:0]         r_wptr;
    logic [AW-1:0]         r_waddr;
    logic [CW-1:0]         r_count;
    logic [INST_WIDTH-1:0] r_rd_data;
    logic                  r_rd_valid;

    logic w_wr_acc;
    logic w_last_addr;
    logic w_commit;
    logic w_ack;
    logic w_rd_acc;
    logic w_rd_hit;

    function automatic logic [PW-1:0] f_inc(input logic [PW-1:0] p);
        return (p == PW'(NUM_BANKS - 1)) ? '0 : p + PW'(1);
    endfunction

    assign wr_ready_o      = (r_count < CW'(NUM_BANKS));
    assign bank_ready_o    = (r_count != '0);
    assign w_wr_acc        = wr_valid_i & (wr_id_i == ID_WIDTH'(ID)) & wr_ready_o;
    assign w_last_addr     = (r_waddr == AW'(INST_WORD - 1));
    // The last slot of a bank always commits; the write address never wraps.
    assign w_commit        = w_wr_acc & (wr_last_i | w_last_addr);
    assign w_ack           = rd_switch_i & bank_ready_o;
    assign rd_switch_ack_o = w_ack;
    assign w_rd_acc        = rd_en_i & bank_ready_o;
    assign w_rd_hit        = (LW'(rd_addr_i) < r_len[r_rptr]);
    assign rd_len_o        = bank_ready_o ? r_len[r_rptr] : '0;
    assign full_count_o    = r_count;
    assign rd_data_o       = r_rd_data;
    assign rd_valid_o      = r_rd_valid;

    // Instruction storage: written only by accepted words, never cleared.
    always_ff @(posedge clk) begin
        if (w_wr_acc) begin
            r_mem[r_wptr][r_waddr] <= wr_data_i;
        end
    end

    // Bank pointers, write address, occupancy and per-bank lengths.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_rptr  <= '0;
            r_wptr  <= '0;
            r_waddr <= '0;
            r_count <= '0;
            for (int i = 0; i < NUM_BANKS; i++) begin
                r_len[i] <= '0;
            end
        end else begin
            if (w_wr_acc) begin
                r_waddr <= w_commit ? '0 : r_waddr + AW'(1);
            end
            // Read and write banks differ whenever both fire, so no index clash.
            if (w_ack) begin
                r_len[r_rptr] <= '0;
                r_rptr        <= f_inc(r_rptr);
            end
            if (w_commit) begin
                r_len[r_wptr] <= LW'(r_waddr) + LW'(1);
                r_wptr        <= f_inc(r_wptr);
            end
            unique case ({w_commit, w_ack})
                2'b10:   r_count <= r_count + CW'(1);
                2'b01:   r_count <= r_count - CW'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    // Fetch port: out-of-range addresses return a zero (NOP) word.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_rd_valid <= 1'b0;
            r_rd_data  <= '0;
        end else begin
            r_rd_valid <= w_rd_acc;
            if (w_rd_acc) begin
                r_rd_data <= w_rd_hit ? r_mem[r_rptr][rd_addr_i] : '0;
            end
        end
    end

endmodule
